// File: rtl/matrix_vector_mac_seq.sv
// Sequential fixed-point matrix-vector engine: y = A*x (+ b), A = M or M transposed,
// one rounded/saturated output element per cycle, valid/ready on both sides.
module matrix_vector_mac_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int DIM        = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   mode_transpose,
  input  logic                                   mode_bias,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] M,
  input  logic [DIM-1:0][DATA_WIDTH-1:0]          x,
  input  logic [DIM-1:0][DATA_WIDTH-1:0]          b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [DIM-1:0][DATA_WIDTH-1:0]          y,
  output logic                                   sat,
  output logic                                   busy
);

  localparam int KW = $clog2(DIM);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = PW + $clog2(DIM) + 1;
  localparam logic [KW-1:0] LAST_K = KW'(DIM - 1);
  localparam logic signed [AW-1:0] ROUND_HALF = {{(AW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] NEG_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    HOLD
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] r_m;
  logic [DIM-1:0][DATA_WIDTH-1:0]          r_x;
  logic [DIM-1:0][DATA_WIDTH-1:0]          r_b;
  logic                                    r_transpose;
  logic                                    r_bias;
  logic [KW-1:0]                           r_k;
  logic                                    r_satAcc;
  logic [DIM-1:0][DATA_WIDTH-1:0]          r_y;
  logic                                    r_sat;

  logic                                    w_accept;
  logic signed [DATA_WIDTH-1:0]            w_coef [DIM];
  logic signed [PW-1:0]                    w_prod [DIM];
  logic signed [AW-1:0]                    w_sum;
  logic signed [DATA_WIDTH-1:0]            w_bSel;
  logic signed [AW-1:0]                    w_biasExt;
  logic signed [AW-1:0]                    w_acc;
  logic signed [AW-1:0]                    w_rounded;
  logic signed [AW-1:0]                    w_shifted;
  logic [AW-DATA_WIDTH:0]                  w_upper;
  logic                                    w_clamp;
  logic [DATA_WIDTH-1:0]                   w_result;

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A retirement in HOLD can coincide with a new acceptance, which restarts COMPUTE directly.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
      end
      COMPUTE: begin
        busy = 1'b1;
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = !rst && out_ready;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    case (r_state)
      IDLE:    if (in_valid && in_ready) w_nextState = COMPUTE;
      COMPUTE: if (r_k == LAST_K) w_nextState = HOLD;
      HOLD: begin
        if (in_valid && in_ready) begin
          w_nextState = COMPUTE;
        end else if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_m         <= M;
      r_x         <= x;
      r_b         <= b;
      r_transpose <= mode_transpose;
      r_bias      <= mode_bias;
    end
  end

  // One full-width multiplier per column; transposition only swaps the row/column select.
  for (genvar g = 0; g < DIM; g++) begin : g_mul
    assign w_coef[g] = r_transpose ? r_m[g][r_k] : r_m[r_k][g];
    assign w_prod[g] = w_coef[g] * $signed(r_x[g]);
  end

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < DIM; j++) begin
      w_sum = w_sum + AW'(w_prod[j]);
    end
  end

  assign w_bSel    = r_b[r_k];
  assign w_biasExt = AW'(w_bSel) <<< FRAC_BITS;
  assign w_acc     = r_bias ? (w_sum + w_biasExt) : w_sum;
  assign w_rounded = w_acc + ROUND_HALF;
  assign w_shifted = w_rounded >>> FRAC_BITS;

  // The value fits when every bit above the result's sign bit matches it.
  assign w_upper  = w_shifted[AW-1:DATA_WIDTH-1];
  assign w_clamp  = !((&w_upper) || !(|w_upper));
  assign w_result = w_clamp ? (w_shifted[AW-1] ? NEG_MIN : POS_MAX)
                            : w_shifted[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_satAcc <= 1'b0;
      r_y      <= '0;
      r_sat    <= 1'b0;
    end else if (w_accept) begin
      r_k      <= '0;
      r_satAcc <= 1'b0;
    end else if (r_state == COMPUTE) begin
      r_y[r_k] <= w_result;
      r_satAcc <= r_satAcc | w_clamp;
      r_k      <= r_k + KW'(1);
      if (r_k == LAST_K) begin
        r_sat <= r_satAcc | w_clamp;
      end
    end
  end

  assign y   = r_y;
  assign sat = r_sat;

endmodule
